// File: rtl/mips_loader_pkg.sv
// rtl/mips_loader_pkg.sv - shared types and constants for the MIPS program loader
package mips_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        PAYLOAD,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES = 2;

endpackage

// File: rtl/mips_word_assembler.sv
// rtl/mips_word_assembler.sv - packs MSB-first bytes into 32-bit words with a running XOR checksum
module mips_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_cnt,
    output logic        word_valid,
    output logic [31:0] word_data,
    output logic [7:0]  checksum
);

    logic [23:0] shift_q;

    // word_data is a separate holding register so the write of word k stays
    // stable while the first byte of word k+1 shifts in.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            byte_cnt   <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
            checksum   <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                shift_q  <= '0;
                byte_cnt <= '0;
                checksum <= '0;
            end else if (byte_en) begin
                shift_q  <= {shift_q[15:0], byte_data};
                byte_cnt <= byte_cnt + 2'd1;
                checksum <= checksum ^ byte_data;
                if (byte_cnt == 2'd3) begin
                    word_data  <= {shift_q, byte_data};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mips_prog_loader.sv
// rtl/mips_prog_loader.sv - boot loader streaming a checksummed image into MIPS instruction memory
module mips_prog_loader
    import mips_loader_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 8,
    parameter int NumWords  = 256
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 Start,
    input  logic [7:0]           Byte_Data,
    input  logic                 Byte_Valid,
    output logic                 Byte_Ready,
    output logic                 IMem_WrEn,
    output logic [AddrWidth-1:0] IMem_WrAddr,
    output logic [DataWidth-1:0] IMem_WrData,
    output logic                 CPU_RST,
    output logic                 Done,
    output logic                 Error
);

    state_t               state_q, state_d;
    logic [15:0]          n_q;
    logic [15:0]          n_full;
    logic [AddrWidth:0]   word_idx;
    logic [AddrWidth-1:0] wr_addr_q;
    logic                 ready_q, done_q, error_q, cpu_rst_q;
    logic                 ready_d, done_d, error_d, cpu_rst_d;
    logic                 accept, go, payload_en, last_byte, last_word;
    logic [1:0]           byte_cnt;
    logic                 word_valid;
    logic [31:0]          word_data;
    logic [7:0]           checksum;

    assign accept     = Byte_Valid && ready_q;
    assign go         = Start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign n_full     = {n_q[15:8], Byte_Data};
    assign payload_en = accept && (state_q == PAYLOAD);
    assign last_byte  = payload_en && (byte_cnt == 2'd3);
    assign last_word  = (int'(word_idx) + 1 == int'(n_q));

    mips_word_assembler u_asm (
        .clk        (clk),
        .rst        (RST),
        .clr        (go),
        .byte_en    (payload_en),
        .byte_data  (Byte_Data),
        .byte_cnt   (byte_cnt),
        .word_valid (word_valid),
        .word_data  (word_data),
        .checksum   (checksum)
    );

    always_ff @(posedge clk) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = HDR_HI;
            HDR_HI:  if (accept) state_d = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if (int'(n_full) > NumWords) state_d = ERR;
                    else if (n_full == 16'd0)    state_d = CHECK;
                    else                         state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (last_byte && last_word) state_d = CHECK;
            CHECK:   if (accept) state_d = (Byte_Data == checksum) ? DONE : ERR;
            DONE:    if (Start) state_d = HDR_HI;
            ERR:     if (Start) state_d = HDR_HI;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state they describe.
    always_comb begin
        ready_d   = (state_d == HDR_HI) || (state_d == HDR_LO) ||
                    (state_d == PAYLOAD) || (state_d == CHECK);
        done_d    = (state_d == DONE);
        error_d   = (state_d == ERR);
        cpu_rst_d = (state_d != DONE);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            n_q       <= '0;
            word_idx  <= '0;
            wr_addr_q <= '0;
        end else if (go) begin
            n_q      <= '0;
            word_idx <= '0;
        end else begin
            if (accept && state_q == HDR_HI) n_q[15:8] <= Byte_Data;
            if (accept && state_q == HDR_LO) n_q <= n_full;
            if (last_byte) begin
                wr_addr_q <= word_idx[AddrWidth-1:0];
                word_idx  <= word_idx + 1'b1;
            end
        end
    end

    assign Byte_Ready  = ready_q;
    assign IMem_WrEn   = word_valid;
    assign IMem_WrAddr = wr_addr_q;
    assign IMem_WrData = word_data;
    assign CPU_RST     = cpu_rst_q;
    assign Done        = done_q;
    assign Error       = error_q;

endmodule
